// File: rtl/sim_link_ctrl_if.sv
// Bundle of the link controller's command, serial and status signals.
// slave: controller side; master: car-control / device side.
interface sim_link_ctrl_if #(
  parameter int CMD_W   = 6,
  parameter int NUM_DET = 4
);
  logic [CMD_W-1:0]   cmd;
  logic               rx;
  logic               tx;
  logic [NUM_DET-1:0] det;
  logic               det_stb;
  logic               link_ok;
  logic               frame_err;
  logic               tx_busy;

  modport slave (
    input  cmd, rx,
    output tx, det, det_stb, link_ok, frame_err, tx_busy
  );

  modport master (
    output cmd, rx,
    input  tx, det, det_stb, link_ok, frame_err, tx_busy
  );
endinterface

// File: rtl/sim_link_ctrl.sv
// Serial link controller: frames cmd into headed 8N1 bytes, receives detector bytes.
// Ports: sys_clk, rst_n (sync, active-low), bus (cmd/rx in; tx/det/status out).
module sim_link_ctrl #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 115200,
  parameter int CMD_W          = 6,
  parameter int NUM_DET        = 4,
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic           sys_clk,
  input logic           rst_n,
  sim_link_ctrl_if.slave bus
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam int RW  = $clog2(REFRESH_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TWO_B = (CMD_W > 6);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [RW-1:0] REF_M1  = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    T_IDLE, T_LOAD, T_START, T_DATA, T_STOP
  } tx_st_t;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  // ---------------- transmitter ----------------
  tx_st_t           tx_st_q;
  logic [CW-1:0]    tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_sh_q;
  logic [7:0]       tx_nx_q;
  logic             tx_byte_q;
  logic [CMD_W-1:0] sent_cmd_q;
  logic             first_q;
  logic [RW-1:0]    ref_q;
  logic             tx_q;
  logic             tx_busy_q;

  logic [11:0] cmd_x;
  logic        trig;
  logic        tx_end;

  assign cmd_x  = 12'(bus.cmd);
  assign trig   = (bus.cmd != sent_cmd_q) | (ref_q == REF_M1) | first_q;
  assign tx_end = (tx_cnt_q == CPB_M1);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      tx_st_q    <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_nx_q    <= '0;
      tx_byte_q  <= 1'b0;
      sent_cmd_q <= '0;
      first_q    <= 1'b1;
      ref_q      <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      unique case (tx_st_q)
        T_IDLE: begin
          if (trig) tx_st_q <= T_LOAD;
          else      ref_q   <= ref_q + 1'b1;
        end
        // Both bytes are built from the same snapshot so a
        // later cmd change cannot tear the frame.
        T_LOAD: begin
          sent_cmd_q <= bus.cmd;
          first_q    <= 1'b0;
          ref_q      <= '0;
          tx_sh_q    <= {2'b10, cmd_x[5:0]};
          tx_nx_q    <= {2'b11, cmd_x[11:6]};
          tx_byte_q  <= 1'b0;
          tx_cnt_q   <= '0;
          tx_q       <= 1'b0;
          tx_busy_q  <= 1'b1;
          tx_st_q    <= T_START;
        end
        T_START: begin
          if (tx_end) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_q     <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            tx_st_q  <= T_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        T_DATA: begin
          if (tx_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              tx_st_q <= T_STOP;
            end else begin
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        T_STOP: begin
          if (tx_end) begin
            tx_cnt_q <= '0;
            if (TWO_B && !tx_byte_q) begin
              tx_sh_q   <= tx_nx_q;
              tx_byte_q <= 1'b1;
              tx_q      <= 1'b0;
              tx_st_q   <= T_START;
            end else begin
              tx_busy_q <= 1'b0;
              tx_st_q   <= T_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_st_q <= T_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= bus.rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_st_t        rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          byte_ok_q;
  logic          frame_err_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rx_st_q     <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      byte_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (rx_st_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_cnt_q <= '0;
            rx_st_q  <= R_START;
          end
        end
        // A line already back high at mid start bit was a glitch.
        R_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == CPB_M1) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_st_q  <= R_STOP;
            else                  rx_bit_q <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == CPB_M1) begin
            rx_cnt_q    <= '0;
            rx_st_q     <= R_IDLE;
            byte_ok_q   <= rx_s2_q;
            frame_err_q <= !rx_s2_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- link status ----------------
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               link_q, link_d;
  logic [NUM_DET-1:0] det_q, det_d;
  logic               stb_q, stb_d;

  // A valid byte takes priority over a simultaneous timeout.
  always_comb begin
    tmo_d  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    link_d = link_q;
    det_d  = det_q;
    stb_d  = 1'b0;
    if (byte_ok_q) begin
      tmo_d  = '0;
      link_d = 1'b1;
      det_d  = rx_sh_q[NUM_DET-1:0];
      stb_d  = 1'b1;
    end else if (tmo_d == TMO_MAX) begin
      link_d = 1'b0;
      det_d  = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      tmo_q  <= '0;
      link_q <= 1'b0;
      det_q  <= '0;
      stb_q  <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      link_q <= link_d;
      det_q  <= det_d;
      stb_q  <= stb_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.tx_busy   = tx_busy_q;
  assign bus.det       = det_q;
  assign bus.det_stb   = stb_q;
  assign bus.link_ok   = link_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_sim_link_ctrl.sv
// Directed bench for sim_link_ctrl: 6-bit and 12-bit command instances.
// Serial frames are logged per cycle and decoded at bit midpoints.
module tb_sim_link_ctrl;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int REF    = 500;
  localparam int TMO    = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sim_link_ctrl_if #(.CMD_W(6),  .NUM_DET(4)) b6 ();
  sim_link_ctrl_if #(.CMD_W(12), .NUM_DET(4)) b12 ();

  sim_link_ctrl #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CMD_W(6), .NUM_DET(4),
    .REFRESH_CYCLES(REF), .TIMEOUT_CYCLES(TMO)
  ) dut6 (
    .sys_clk(clk), .rst_n(rst_n), .bus(b6.slave)
  );

  sim_link_ctrl #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CMD_W(12), .NUM_DET(4),
    .REFRESH_CYCLES(REF), .TIMEOUT_CYCLES(TMO)
  ) dut12 (
    .sys_clk(clk), .rst_n(rst_n), .bus(b12.slave)
  );

  int checks = 0;
  int errors = 0;
  logic tx_log [0:399];
  int busy_cnt;
  int waited;
  int stb_cnt = 0;
  int ferr_cnt = 0;
  int cyc = 0;
  int stb_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (b6.det_stb === 1'b1) begin
      stb_cnt++;
      stb_cyc = cyc;
    end
    if (b6.frame_err === 1'b1) ferr_cnt++;
  end

  function automatic logic [7:0] log_byte(input int b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = tx_log[b*100 + 15 + 10*k];
    return r;
  endfunction

  function automatic bit log_framed(input int b);
    return tx_log[b*100] === 1'b0 && tx_log[b*100+5] === 1'b0 &&
           tx_log[b*100+95] === 1'b1;
  endfunction

  // Waits (bounded) for a start bit, then logs nbytes*100 cycles.
  task automatic capture(input bit sel, input int nbytes,
                         input int chg_at, input logic [11:0] chg_val);
    waited = 0;
    while ((sel ? b12.tx : b6.tx) !== 1'b0 && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    busy_cnt = 0;
    for (int i = 0; i < nbytes*100; i++) begin
      tx_log[i] = sel ? b12.tx : b6.tx;
      if ((sel ? b12.tx_busy : b6.tx_busy) === 1'b1) busy_cnt++;
      if (i == chg_at) b12.cmd = chg_val;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    b6.rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      b6.rx = b[k];
      repeat (10) @(posedge clk);
      #1;
    end
    b6.rx = stop;
    repeat (10) @(posedge clk);
    #1;
    b6.rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    b6.cmd = 6'b000001;
    b6.rx = 1'b1;
    b12.cmd = 12'hA05;
    b12.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b6.tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx got %b want 1", b6.tx);
    end
    checks++;
    if (b6.det !== 4'h0) begin
      errors++; $display("FAIL reset_det got %h want 0", b6.det);
    end
    checks++;
    if (b6.det_stb !== 1'b0) begin
      errors++; $display("FAIL reset_stb got %b want 0", b6.det_stb);
    end
    checks++;
    if (b6.link_ok !== 1'b0) begin
      errors++; $display("FAIL reset_link got %b want 0", b6.link_ok);
    end
    checks++;
    if (b6.frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_ferr got %b want 0", b6.frame_err);
    end
    checks++;
    if (b6.tx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", b6.tx_busy);
    end
    checks++;
    if (b12.tx !== 1'b1 || b12.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_12 got tx=%b busy=%b want 1/0", b12.tx, b12.tx_busy);
    end
  endtask

  task automatic test_first_frame;
    rst_n = 1'b1;
    capture(1'b0, 1, -1, 12'h000);
    checks++;
    if (waited != 2) begin
      errors++; $display("FAIL first_lat got %0d want 2", waited);
    end
    checks++;
    if (!log_framed(0)) begin
      errors++; $display("FAIL first_framing got 0 want 1");
    end
    checks++;
    if (log_byte(0) !== 8'h81) begin
      errors++; $display("FAIL first_byte got %h want 81", log_byte(0));
    end
    checks++;
    if (busy_cnt != 100) begin
      errors++; $display("FAIL first_busy got %0d want 100", busy_cnt);
    end
    checks++;
    if (b6.tx_busy !== 1'b0 || b6.tx !== 1'b1) begin
      errors++;
      $display("FAIL first_end got busy=%b tx=%b want 0/1", b6.tx_busy, b6.tx);
    end
  endtask

  task automatic test_refresh;
    int low;
    bit quiet;
    low = 0;
    quiet = 1'b1;
    while (b6.tx_busy !== 1'b1 && low < 1000) begin
      if (b6.tx !== 1'b1) quiet = 1'b0;
      @(posedge clk); #1;
      low++;
    end
    checks++;
    if (low != 501) begin
      errors++; $display("FAIL refresh_gap got %0d want 501", low);
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL refresh_quiet got 0 want 1");
    end
    capture(1'b0, 1, -1, 12'h000);
    checks++;
    if (waited != 0 || log_byte(0) !== 8'h81) begin
      errors++;
      $display("FAIL refresh_byte got %h lat %0d want 81 lat 0", log_byte(0), waited);
    end
  endtask

  task automatic test_cmd_change;
    b6.cmd = 6'b001100;
    capture(1'b0, 1, -1, 12'h000);
    checks++;
    if (waited != 2) begin
      errors++; $display("FAIL change_lat got %0d want 2", waited);
    end
    checks++;
    if (log_byte(0) !== 8'h8C || !log_framed(0)) begin
      errors++; $display("FAIL change_byte got %h want 8c", log_byte(0));
    end
  endtask

  task automatic test_two_byte;
    rst_n = 1'b0;
    b12.cmd = 12'hA05;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    capture(1'b1, 2, 50, 12'h000);
    checks++;
    if (waited != 2) begin
      errors++; $display("FAIL two_lat got %0d want 2", waited);
    end
    checks++;
    if (!log_framed(0) || !log_framed(1)) begin
      errors++; $display("FAIL two_framing got 0 want 1");
    end
    checks++;
    if (log_byte(0) !== 8'h85 || log_byte(1) !== 8'hE8) begin
      errors++;
      $display("FAIL two_bytes got %h %h want 85 e8", log_byte(0), log_byte(1));
    end
    checks++;
    if (busy_cnt != 200) begin
      errors++; $display("FAIL two_busy got %0d want 200", busy_cnt);
    end
    capture(1'b1, 2, -1, 12'h000);
    checks++;
    if (waited != 2) begin
      errors++; $display("FAIL two_next_lat got %0d want 2", waited);
    end
    checks++;
    if (log_byte(0) !== 8'h80 || log_byte(1) !== 8'hC0) begin
      errors++;
      $display("FAIL two_next got %h %h want 80 c0", log_byte(0), log_byte(1));
    end
  endtask

  task automatic test_rx_valid;
    int s0, f0;
    s0 = stb_cnt;
    f0 = ferr_cnt;
    send_rx(8'h0B, 1'b1);
    checks++;
    if (stb_cnt - s0 != 1) begin
      errors++; $display("FAIL rx_stb got %0d want 1", stb_cnt - s0);
    end
    checks++;
    if (ferr_cnt - f0 != 0) begin
      errors++; $display("FAIL rx_ferr got %0d want 0", ferr_cnt - f0);
    end
    checks++;
    if (b6.det !== 4'b1011) begin
      errors++; $display("FAIL rx_det got %b want 1011", b6.det);
    end
    checks++;
    if (b6.link_ok !== 1'b1) begin
      errors++; $display("FAIL rx_link got %b want 1", b6.link_ok);
    end
  endtask

  task automatic test_rx_errors;
    int s0, f0;
    s0 = stb_cnt;
    f0 = ferr_cnt;
    send_rx(8'hF4, 1'b0);
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++; $display("FAIL bad_stop_ferr got %0d want 1", ferr_cnt - f0);
    end
    checks++;
    if (stb_cnt - s0 != 0 || b6.det !== 4'b1011) begin
      errors++;
      $display("FAIL bad_stop_det got %b stb %0d want 1011 stb 0", b6.det, stb_cnt - s0);
    end
    s0 = stb_cnt;
    f0 = ferr_cnt;
    b6.rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    b6.rx = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    checks++;
    if (stb_cnt - s0 != 0 || ferr_cnt - f0 != 0) begin
      errors++;
      $display("FAIL glitch got stb %0d ferr %0d want 0 0", stb_cnt - s0, ferr_cnt - f0);
    end
  endtask

  task automatic test_timeout;
    send_rx(8'h06, 1'b1);
    checks++;
    if (b6.det !== 4'b0110 || b6.link_ok !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start got det %b link %b want 0110 1", b6.det, b6.link_ok);
    end
    while (cyc < stb_cyc + TMO - 10) @(negedge clk);
    checks++;
    if (b6.link_ok !== 1'b1 || b6.det !== 4'b0110) begin
      errors++;
      $display("FAIL tmo_before got link %b det %b want 1 0110", b6.link_ok, b6.det);
    end
    while (cyc < stb_cyc + TMO + 10) @(negedge clk);
    checks++;
    if (b6.link_ok !== 1'b0 || b6.det !== 4'b0000) begin
      errors++;
      $display("FAIL tmo_after got link %b det %b want 0 0000", b6.link_ok, b6.det);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    b6.cmd = 6'b010101;
    while (b6.tx_busy !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b6.tx !== 1'b0) begin
      errors++; $display("FAIL mid_pre got %b want 0", b6.tx);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (b6.tx !== 1'b1 || b6.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got tx %b busy %b want 1 0", b6.tx, b6.tx_busy);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_refresh();
    test_cmd_change();
    test_two_byte();
    test_rx_valid();
    test_rx_errors();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
